// File: rtl/fetch_if.sv
// Handshake and memory bus between the fetch stage, instruction memory and decode.
interface fetch_if #(
   parameter int ADDR_SIZE = 10,
   parameter int WORD_SIZE = 32
) ();
   logic                 fetch_en;
   logic                 redirect_valid;
   logic [ADDR_SIZE-1:0] redirect_pc;
   logic [ADDR_SIZE-1:0] imem_addr;
   logic [WORD_SIZE-1:0] imem_instr;
   logic                 out_valid;
   logic                 out_ready;
   logic [WORD_SIZE-1:0] out_instr;
   logic [ADDR_SIZE-1:0] out_pc;

   modport master (
      input  fetch_en, redirect_valid, redirect_pc, imem_instr, out_ready,
      output imem_addr, out_valid, out_instr, out_pc
   );

   modport slave (
      output fetch_en, redirect_valid, redirect_pc, imem_instr, out_ready,
      input  imem_addr, out_valid, out_instr, out_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, one-cycle memory latency tracking, 2-entry
// output queue to decode, and redirect flush.
module fetch_unit #(
   parameter int                 ADDR_SIZE = 10,
   parameter int                 WORD_SIZE = 32,
   parameter logic [ADDR_SIZE-1:0] RESET_PC = '0
) (
   input  logic      clk,
   input  logic      rst_n,
   fetch_if.master   bus
);
   logic [ADDR_SIZE-1:0] pc_q, pc_d, inf_pc_q, inf_pc_d;
   logic                 inf_q, inf_d;
   logic [1:0]           count_q, count_d;
   logic                 rd_q, rd_d, wr_q, wr_d;
   logic [WORD_SIZE-1:0] q_instr_q [2];
   logic [ADDR_SIZE-1:0] q_pc_q [2];
   logic                 pop, push, issue;
   logic [1:0]           credit;

   always_comb begin
      pop      = (count_q != 2'd0) && bus.out_ready;
      push     = inf_q && !bus.redirect_valid;
      // Slots already promised: what stays queued plus the word still in flight.
      credit   = count_q - {1'b0, pop} + {1'b0, inf_q};
      issue    = bus.fetch_en && !bus.redirect_valid && (credit < 2'd2);
      pc_d     = pc_q;
      inf_pc_d = inf_pc_q;
      inf_d    = 1'b0;
      count_d  = count_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      if (bus.redirect_valid) begin
         pc_d    = bus.redirect_pc & ~ADDR_SIZE'(3);
         count_d = 2'd0;
         rd_d    = 1'b0;
         wr_d    = 1'b0;
      end else begin
         inf_d   = issue;
         if (issue) begin
            pc_d     = pc_q + ADDR_SIZE'(4);
            inf_pc_d = pc_q;
         end
         rd_d    = rd_q ^ pop;
         wr_d    = wr_q ^ push;
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         inf_pc_q <= '0;
         inf_q    <= 1'b0;
         count_q  <= 2'd0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            q_instr_q[i] <= '0;
            q_pc_q[i]    <= '0;
         end
      end else begin
         pc_q     <= pc_d;
         inf_pc_q <= inf_pc_d;
         inf_q    <= inf_d;
         count_q  <= count_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         if (push) begin
            q_instr_q[wr_q] <= bus.imem_instr;
            q_pc_q[wr_q]    <= inf_pc_q;
         end
      end
   end

   // Outputs come straight from state so an async reset clears them at once.
   assign bus.imem_addr = pc_q;
   assign bus.out_valid = (count_q != 2'd0);
   assign bus.out_instr = bus.out_valid ? q_instr_q[rd_q] : '0;
   assign bus.out_pc    = bus.out_valid ? q_pc_q[rd_q]    : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-level reference model and
// a per-cycle compare against it.
module tb_fetch_unit;
   localparam int AW = 10;
   localparam int WW = 32;

   logic clk, rst_n;
   int   errors = 0;
   int   checks = 0;

   fetch_if #(.ADDR_SIZE(AW), .WORD_SIZE(WW)) bus ();

   fetch_unit #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .RESET_PC('0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous memory, word[i] = i.
   always @(posedge clk) bus.imem_instr <= WW'(bus.imem_addr >> 2);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: queue of PCs awaiting decode plus an optional in-flight PC.
   logic [AW-1:0] mq[$];
   logic [AW-1:0] mpc, mipc;
   bit            minf;

   task automatic mreset();
      mq.delete();
      mpc  = '0;
      mipc = '0;
      minf = 0;
   endtask

   task automatic mstep();
      int  sz;
      bit  pop, iss;
      sz  = mq.size();
      pop = (sz > 0) && bus.out_ready;
      if (bus.redirect_valid) begin
         mq.delete();
         minf = 0;
         mpc  = {bus.redirect_pc[AW-1:2], 2'b00};
      end else begin
         iss = bus.fetch_en && ((sz - int'(pop) + int'(minf)) < 2);
         if (pop) void'(mq.pop_front());
         if (minf) mq.push_back(mipc);
         minf = iss;
         if (iss) begin
            mipc = mpc;
            mpc  = AW'((int'(mpc) + 4) % 1024);
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mreset();
      else        mstep();
   end

   // Delivered instructions as seen by decode.
   logic [AW-1:0] got_pc[$];
   logic [WW-1:0] got_in[$];

   always @(negedge clk) begin
      if (rst_n) begin
         chk("valid", {31'b0, bus.out_valid}, {31'b0, mq.size() != 0});
         chk("addr", 32'(bus.imem_addr), 32'(mpc));
         chk("pc", 32'(bus.out_pc), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
         chk("instr", bus.out_instr, (mq.size() != 0) ? 32'(mq[0] >> 2) : 32'd0);
         if (bus.out_valid && bus.out_ready) begin
            got_pc.push_back(bus.out_pc);
            got_in.push_back(bus.out_instr);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [AW-1:0] tgt);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = tgt;
      tick();
      bus.redirect_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.fetch_en = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      bus.out_ready = 1'b0;
      tick(); tick();
      chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_addr", 32'(bus.imem_addr), 32'd0);
      chk("rst_pc", 32'(bus.out_pc), 32'd0);
      chk("rst_instr", bus.out_instr, 32'd0);

      // Streaming from reset.
      rst_n = 1'b1; bus.fetch_en = 1'b1; bus.out_ready = 1'b1;
      chk("c0_addr", 32'(bus.imem_addr), 32'd0);
      tick();
      chk("c1_valid", {31'b0, bus.out_valid}, 32'd0);
      tick();
      chk("c2_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("c2_pc", 32'(bus.out_pc), 32'd0);
      repeat (6) tick();
      chk("stream_n", got_pc.size(), 32'd6);
      for (int i = 0; i < got_pc.size(); i++) begin
         chk("stream_pc", 32'(got_pc[i]), 32'(4 * i));
         chk("stream_in", got_in[i], 32'(i));
      end

      // Backpressure.
      got_pc.delete(); got_in.delete();
      bus.out_ready = 1'b0;
      repeat (5) tick();
      chk("bp_none", got_pc.size(), 32'd0);
      chk("bp_addr", 32'(bus.imem_addr), 32'h20);
      chk("bp_head", 32'(bus.out_pc), 32'h18);
      bus.out_ready = 1'b1;
      repeat (4) tick();
      chk("bp_n", got_pc.size(), 32'd4);
      for (int i = 0; i < got_pc.size(); i++)
         chk("bp_pc", 32'(got_pc[i]), 32'(32'h18 + 4 * i));

      // Redirect with a full queue.
      bus.out_ready = 1'b0;
      repeat (3) tick();
      got_pc.delete(); got_in.delete();
      redirect(10'h103);
      bus.out_ready = 1'b1;
      chk("r1_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("r1_addr", 32'(bus.imem_addr), 32'h100);
      tick();
      chk("r2_valid", {31'b0, bus.out_valid}, 32'd0);
      tick();
      chk("r3_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("r3_pc", 32'(bus.out_pc), 32'h100);
      chk("r3_instr", bus.out_instr, 32'h40);
      repeat (3) tick();
      chk("r_n", got_pc.size(), 32'd3);
      for (int i = 0; i < got_pc.size(); i++)
         chk("r_pc", 32'(got_pc[i]), 32'(32'h100 + 4 * i));

      // Redirect together with an accepted pop.
      got_pc.delete(); got_in.delete();
      redirect(10'h200);
      repeat (4) tick();
      chk("rp_n", got_pc.size(), 32'd3);
      if (got_pc.size() == 3) begin
         chk("rp_pc0", 32'(got_pc[0]), 32'h10C);
         chk("rp_pc1", 32'(got_pc[1]), 32'h200);
         chk("rp_pc2", 32'(got_pc[2]), 32'h204);
      end

      // Address wrap.
      redirect(10'h3F8);
      got_pc.delete(); got_in.delete();
      repeat (5) tick();
      chk("wr_n", got_pc.size(), 32'd3);
      if (got_pc.size() == 3) begin
         chk("wr_pc0", 32'(got_pc[0]), 32'h3F8);
         chk("wr_pc1", 32'(got_pc[1]), 32'h3FC);
         chk("wr_pc2", 32'(got_pc[2]), 32'h000);
         chk("wr_in0", got_in[0], 32'hFE);
         chk("wr_in2", got_in[2], 32'h0);
      end

      // Asynchronous reset with two entries queued.
      bus.out_ready = 1'b0;
      repeat (3) tick();
      chk("ar_pre", {31'b0, bus.out_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("ar_pc", 32'(bus.out_pc), 32'd0);
      chk("ar_addr", 32'(bus.imem_addr), 32'd0);
      tick();
      rst_n = 1'b1; bus.out_ready = 1'b1;
      tick(); tick();
      chk("ar_restart_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("ar_restart_pc", 32'(bus.out_pc), 32'd0);
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
